// File: rtl/Common.sv
// Common: shared types for the decode queue and its instruction decoder.
//   Signals  - decoded control bundle carried through the queue
//   Op       - ALU operation (base RV32I plus M-extension members)
//   Cond     - branch/jump condition evaluated by execute
//   Sel      - ALU operand source select
//   MemType  - load/store access size and signedness
//   Opcode   - RV32 major opcodes recognised by the decoder
// Helpers: nop_signals() builds the idle bundle, alu_op()/mul_op() map funct3.
package Common;

  typedef enum logic [4:0] {
    Add, Sub, USub, Sll, Slt, Sltu, Xor, Srl, Sra, Or, And,
    Mul, Mulh, Mulhsu, Mulhu, Div, Divu, Rem, Remu
  } Op;

  typedef enum logic [2:0] {
    Never, Always, Zero, NotZero, Carry, NotCarry
  } Cond;

  typedef enum logic [1:0] {
    Register, Immediate, ProgramCounter
  } Sel;

  typedef enum logic [2:0] {
    LoadByte, LoadHalf, LoadWord, LoadByteU, LoadHalfU, StoreByte, StoreHalf, StoreWord
  } MemType;

  typedef enum logic [6:0] {
    Load   = 7'h03,
    RegImm = 7'h13,
    Auipc  = 7'h17,
    Store  = 7'h23,
    RegReg = 7'h33,
    Lui    = 7'h37,
    Branch = 7'h63,
    Jalr   = 7'h67,
    Jal    = 7'h6F
  } Opcode;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    Op           op;
    logic        wreg;   // write result to rd
    Sel          asel;
    Sel          bsel;
    logic        pcsel;  // 1: jump target from register (jalr)
    Cond         cond;
    logic        memr;
    logic        memw;
    MemType      memt;
  } Signals;

  function automatic Signals nop_signals(input logic [31:0] pc);
    Signals s;
    s.valid = 1'b0;
    s.pc    = pc;
    s.op    = Add;
    s.wreg  = 1'b0;
    s.asel  = Register;
    s.bsel  = Register;
    s.pcsel = 1'b0;
    s.cond  = Never;
    s.memr  = 1'b0;
    s.memw  = 1'b0;
    s.memt  = LoadByte;
    return s;
  endfunction

  // Base ALU op for funct3 with funct7 = 0.
  function automatic Op alu_op(input logic [2:0] f3);
    unique case (f3)
      3'd0: return Add;
      3'd1: return Sll;
      3'd2: return Slt;
      3'd3: return Sltu;
      3'd4: return Xor;
      3'd5: return Srl;
      3'd6: return Or;
      default: return And;
    endcase
  endfunction

  function automatic Op mul_op(input logic [2:0] f3);
    unique case (f3)
      3'd0: return Mul;
      3'd1: return Mulh;
      3'd2: return Mulhsu;
      3'd3: return Mulhu;
      3'd4: return Div;
      3'd5: return Divu;
      3'd6: return Rem;
      default: return Remu;
    endcase
  endfunction

endpackage

// File: rtl/insn_decoder.sv
// insn_decoder: purely combinational RV32 decode of one instruction word.
// Ports:
//   i_insn    - raw instruction word
//   i_pc      - address of i_insn, copied into the bundle
//   o_signals - decoded control bundle (valid always 1)
//   o_illegal - instruction not recognised
// Build option: DECODE_QUEUE_MEXT_EN enables the M-extension (funct7 0x01 on RegReg);
// without it those encodings are illegal.
module insn_decoder
  import Common::*;
(
  input  logic [31:0] i_insn,
  input  logic [31:0] i_pc,
  output Signals      o_signals,
  output logic        o_illegal
);

  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_unused_bits;
  Signals     w_sig;
  logic       w_ill;

  assign w_opc = i_insn[6:0];
  assign w_f3  = i_insn[14:12];
  assign w_f7  = i_insn[31:25];
  // Register/immediate fields are not part of this bundle.
  assign w_unused_bits = ^{i_insn[24:15], i_insn[11:7]};

  always_comb begin
    w_sig       = nop_signals(i_pc);
    w_sig.valid = 1'b1;
    w_ill       = 1'b0;

    case (w_opc)
      RegImm: begin
        w_sig.wreg = 1'b1;
        w_sig.bsel = Immediate;
        w_sig.op   = alu_op(w_f3);
        if (w_f3 == 3'd1) begin
          w_ill = (w_f7 != 7'h00);
        end else if (w_f3 == 3'd5) begin
          if (w_f7 == 7'h20) begin
            w_sig.op = Sra;
          end else if (w_f7 != 7'h00) begin
            w_ill = 1'b1;
          end
        end
      end
      RegReg: begin
        w_sig.wreg = 1'b1;
        case (w_f7)
          7'h00: w_sig.op = alu_op(w_f3);
          7'h20: begin
            if (w_f3 == 3'd0) begin
              w_sig.op = Sub;
            end else if (w_f3 == 3'd5) begin
              w_sig.op = Sra;
            end else begin
              w_ill = 1'b1;
            end
          end
`ifdef DECODE_QUEUE_MEXT_EN
          7'h01: w_sig.op = mul_op(w_f3);
`else
          7'h01: w_ill = 1'b1;
`endif
          default: w_ill = 1'b1;
        endcase
      end
      Load: begin
        w_sig.wreg = 1'b1;
        w_sig.bsel = Immediate;
        w_sig.memr = 1'b1;
        case (w_f3)
          3'd0: w_sig.memt = LoadByte;
          3'd1: w_sig.memt = LoadHalf;
          3'd2: w_sig.memt = LoadWord;
          3'd4: w_sig.memt = LoadByteU;
          3'd5: w_sig.memt = LoadHalfU;
          default: w_ill = 1'b1;
        endcase
      end
      Store: begin
        w_sig.bsel = Immediate;
        w_sig.memw = 1'b1;
        case (w_f3)
          3'd0: w_sig.memt = StoreByte;
          3'd1: w_sig.memt = StoreHalf;
          3'd2: w_sig.memt = StoreWord;
          default: w_ill = 1'b1;
        endcase
      end
      Branch: begin
        // Signed compares use Sub, unsigned use USub; lt/ge read the borrow as carry.
        unique case (w_f3)
          3'd0: begin w_sig.op = Sub;  w_sig.cond = Zero;     end
          3'd1: begin w_sig.op = Sub;  w_sig.cond = NotZero;  end
          3'd4: begin w_sig.op = Sub;  w_sig.cond = Carry;    end
          3'd5: begin w_sig.op = Sub;  w_sig.cond = NotCarry; end
          3'd6: begin w_sig.op = USub; w_sig.cond = Carry;    end
          3'd7: begin w_sig.op = USub; w_sig.cond = NotCarry; end
          default: w_ill = 1'b1;
        endcase
      end
      Jal, Jalr: begin
        w_sig.wreg  = 1'b1;
        w_sig.asel  = ProgramCounter;
        w_sig.bsel  = Immediate;
        w_sig.cond  = Always;
        w_sig.pcsel = (w_opc == Jalr);
        w_ill       = (w_opc == Jalr) && (w_f3 != 3'd0);
      end
      Lui: begin
        w_sig.wreg = 1'b1;
        w_sig.bsel = Immediate;
      end
      Auipc: begin
        w_sig.wreg = 1'b1;
        w_sig.asel = ProgramCounter;
        w_sig.bsel = Immediate;
      end
      default: w_ill = 1'b1;
    endcase

    // Illegal entries carry a harmless bundle: no write, no memory access, no jump.
    if (w_ill) begin
      w_sig       = nop_signals(i_pc);
      w_sig.valid = 1'b1;
    end
  end

  assign o_signals = w_sig;
  assign o_illegal = w_ill;

endmodule

// File: rtl/decode_queue.sv
// decode_queue: decodes fetched instructions on entry and buffers the decoded bundles
// in a DEPTH-slot circular queue between fetch and execute.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   flush               - drop every queued entry (branch redirect)
//   in_valid/in_ready   - fetch handshake; in_insn/in_pc carry the instruction
//   out_valid/out_ready - execute handshake on the head entry
//   out_signals         - decoded head bundle (NOP bundle at RESET_PC when empty)
//   out_illegal         - head entry failed to decode
// Build option: DECODE_QUEUE_MEXT_EN (passed to insn_decoder) enables the M-extension.
module decode_queue
  import Common::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_insn,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output Signals      out_signals,
  output logic        out_illegal
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [CntW-1:0] r_count;
  logic [PtrW-1:0] r_wr;
  logic [PtrW-1:0] r_rd;
  Signals          r_sig [DEPTH];
  logic            r_ill [DEPTH];

  Signals          w_dec;
  logic            w_dec_ill;
  logic            w_push;
  logic            w_pop;
  logic [PtrW-1:0] w_wr_nxt;
  logic [PtrW-1:0] w_rd_nxt;

  insn_decoder u_dec (
    .i_insn    (in_insn),
    .i_pc      (in_pc),
    .o_signals (w_dec),
    .o_illegal (w_dec_ill)
  );

  // Only registered state feeds the handshake outputs, so no in-to-out path exists.
  assign in_ready  = (r_count < CntW'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;

  // Explicit wrap so DEPTH need not be a power of two.
  assign w_wr_nxt = (r_wr == PtrW'(DEPTH - 1)) ? '0 : r_wr + PtrW'(1);
  assign w_rd_nxt = (r_rd == PtrW'(DEPTH - 1)) ? '0 : r_rd + PtrW'(1);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_count <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
    end else begin
      if (w_push) r_wr <= w_wr_nxt;
      if (w_pop)  r_rd <= w_rd_nxt;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_sig[r_wr] <= w_dec;
      r_ill[r_wr] <= w_dec_ill;
    end
  end

  always_comb begin
    out_signals = nop_signals(RESET_PC);
    out_illegal = 1'b0;
    if (out_valid) begin
      out_signals = r_sig[r_rd];
      out_illegal = r_ill[r_rd];
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;
  import Common::*;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_1000;
`ifdef DECODE_QUEUE_MEXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_insn, in_pc;
  Signals      out_signals;

  int n_vec  = 0;
  int n_fail = 0;
  logic [63:0] mq[$];  // expected contents, {pc, insn}, head at index 0

  always #5 clk = ~clk;

  decode_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_insn     (in_insn),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_signals (out_signals),
    .out_illegal (out_illegal)
  );

  // Reference decode straight from the instruction-set tables.
  function automatic void ref_decode(input logic [31:0] w, input logic [31:0] pc,
                                     output Signals s, output logic ill);
    logic [2:0] f3;
    logic [6:0] f7;
    Op      base [8] = '{Add, Sll, Slt, Sltu, Xor, Srl, Or, And};
    Op      mext [8] = '{Mul, Mulh, Mulhsu, Mulhu, Div, Divu, Rem, Remu};
    Cond    bc   [8] = '{Zero, NotZero, Never, Never, Carry, NotCarry, Carry, NotCarry};
    MemType lt   [8] = '{LoadByte, LoadHalf, LoadWord, LoadByte,
                         LoadByteU, LoadHalfU, LoadByte, LoadByte};
    MemType st   [4] = '{StoreByte, StoreHalf, StoreWord, LoadByte};
    f3 = w[14:12];
    f7 = w[31:25];
    s.valid = 1'b1; s.pc = pc; s.op = Add; s.wreg = 1'b0; s.asel = Register;
    s.bsel = Register; s.pcsel = 1'b0; s.cond = Never; s.memr = 1'b0; s.memw = 1'b0;
    s.memt = LoadByte;
    ill = 1'b0;
    case (w[6:0])
      7'h13: begin
        s.wreg = 1'b1; s.bsel = Immediate; s.op = base[f3];
        if (f3 == 3'd5 && f7 == 7'h20) s.op = Sra;
        ill = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
      end
      7'h33: begin
        s.wreg = 1'b1;
        if (f7 == 7'h00) s.op = base[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) s.op = Sub;
        else if (f7 == 7'h20 && f3 == 3'd5) s.op = Sra;
        else if (f7 == 7'h01 && MEXT) s.op = mext[f3];
        else ill = 1'b1;
      end
      7'h03: begin
        s.wreg = 1'b1; s.memr = 1'b1; s.bsel = Immediate; s.memt = lt[f3];
        ill = (f3 == 3'd3) || (f3 >= 3'd6);
      end
      7'h23: begin
        s.memw = 1'b1; s.bsel = Immediate; s.memt = st[f3[1:0]];
        ill = (f3 > 3'd2);
      end
      7'h63: begin
        s.op = (f3 >= 3'd6) ? USub : Sub; s.cond = bc[f3];
        ill = (f3 == 3'd2) || (f3 == 3'd3);
      end
      7'h6F, 7'h67: begin
        s.wreg = 1'b1; s.asel = ProgramCounter; s.bsel = Immediate; s.cond = Always;
        s.pcsel = (w[6:0] == 7'h67);
        ill = (w[6:0] == 7'h67) && (f3 != 3'd0);
      end
      7'h37: begin s.wreg = 1'b1; s.bsel = Immediate; end
      7'h17: begin s.wreg = 1'b1; s.bsel = Immediate; s.asel = ProgramCounter; end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      s.op = Add; s.wreg = 1'b0; s.asel = Register; s.bsel = Register; s.pcsel = 1'b0;
      s.cond = Never; s.memr = 1'b0; s.memw = 1'b0; s.memt = LoadByte;
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    Signals e;
    logic   ei;
    if (mq.size() != 0) begin
      ref_decode(mq[0][31:0], mq[0][63:32], e, ei);
    end else begin
      e.valid = 1'b0; e.pc = RPC; e.op = Add; e.wreg = 1'b0; e.asel = Register;
      e.bsel = Register; e.pcsel = 1'b0; e.cond = Never; e.memr = 1'b0; e.memw = 1'b0;
      e.memt = LoadByte;
      ei = 1'b0;
    end
    chk({tag, " out_valid"}, 64'(out_valid), 64'(mq.size() != 0));
    chk({tag, " in_ready"}, 64'(in_ready), 64'(mq.size() < DEPTH));
    chk({tag, " out_illegal"}, 64'(out_illegal), 64'(ei));
    chk({tag, " out_signals"}, 64'(out_signals), 64'(e));
  endtask

  // One clock: check the current outputs, drive inputs, advance the model.
  task automatic step(input logic v, input logic [31:0] insn, input logic [31:0] pc,
                      input logic ordy, input logic fl, input logic r, input string tag);
    logic push, pop;
    check_outputs(tag);
    in_valid = v; in_insn = insn; in_pc = pc; out_ready = ordy; flush = fl; rst = r;
    push = v && (mq.size() < DEPTH) && !fl;
    pop  = (mq.size() != 0) && ordy && !fl;
    @(posedge clk);
    if (r || fl) begin
      mq.delete();
    end else begin
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back({pc, insn});
    end
    #1;
  endtask

  function automatic logic [31:0] addi(input int k);
    return {12'(k), 5'd0, 3'd0, 5'd1, 7'h13};
  endfunction

  function automatic logic [31:0] rand_insn();
    logic [6:0] opcs [9] = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F};
    logic [6:0] f7s  [4] = '{7'h00, 7'h20, 7'h01, 7'h00};
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 4) != 0) begin
      w[6:0] = opcs[$urandom_range(0, 8)];
      if ($urandom_range(0, 3) != 0) w[31:25] = f7s[$urandom_range(0, 3)];
    end
    return w;
  endfunction

  initial begin
    int k;
    bit acc;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_insn = '0; in_pc = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, then single addi with one-cycle latency.
    chk("reset in_ready", 64'(in_ready), 64'd1);
    step(1'b1, 32'h0050_0093, 32'h100, 1'b0, 1'b0, 1'b0, "addi push");
    chk("addi op", 64'(out_signals.op), 64'(Add));
    chk("addi wreg", 64'(out_signals.wreg), 64'd1);
    chk("addi bsel", 64'(out_signals.bsel), 64'(Immediate));
    chk("addi pc", 64'(out_signals.pc), 64'h100);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, "addi pop");

    // Fill to full with out_ready low; third push refused.
    step(1'b1, 32'h0010_0113, 32'h200, 1'b0, 1'b0, 1'b0, "fill a");
    step(1'b1, 32'h0020_0193, 32'h204, 1'b0, 1'b0, 1'b0, "fill b");
    chk("full in_ready", 64'(in_ready), 64'd0);
    step(1'b1, 32'h0030_0213, 32'h208, 1'b0, 1'b0, 1'b0, "fill c");
    repeat (3) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, "drain");
    chk("drained out_valid", 64'(out_valid), 64'd0);

    // Streaming at full with fetch holding its instruction until accepted.
    step(1'b1, addi(100), 32'h1F00, 1'b0, 1'b0, 1'b0, "prefill");
    step(1'b1, addi(101), 32'h1F04, 1'b0, 1'b0, 1'b0, "prefill");
    k = 0;
    for (int cyc = 0; cyc < 100 && k < 20; cyc++) begin
      acc = (mq.size() < DEPTH);
      step(1'b1, addi(k), 32'h2000 + 32'(4 * k), 1'b1, 1'b0, 1'b0, "stream");
      if (acc) k++;
    end
    chk("stream accepted", 64'(k), 64'd20);
    repeat (3) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, "stream drain");

    // Flush with a simultaneous push drops everything.
    step(1'b1, 32'h0010_0113, 32'h300, 1'b0, 1'b0, 1'b0, "pre-flush a");
    step(1'b1, 32'h0020_0193, 32'h304, 1'b0, 1'b0, 1'b0, "pre-flush b");
    step(1'b1, 32'h0030_0213, 32'h308, 1'b1, 1'b1, 1'b0, "flush");
    chk("flush out_valid", 64'(out_valid), 64'd0);
    chk("flush in_ready", 64'(in_ready), 64'd1);

    // M-extension word.
    step(1'b1, 32'h0220_8033, 32'h400, 1'b0, 1'b0, 1'b0, "mul push");
    chk("mul illegal", 64'(out_illegal), MEXT ? 64'd0 : 64'd1);
    chk("mul op", 64'(out_signals.op), MEXT ? 64'(Mul) : 64'(Add));
    chk("mul wreg", 64'(out_signals.wreg), MEXT ? 64'd1 : 64'd0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, "mul pop");

    // Illegal store width and all-ones word.
    step(1'b1, 32'h0000_B023, 32'h500, 1'b0, 1'b0, 1'b0, "sd push");
    step(1'b1, 32'hFFFF_FFFF, 32'h504, 1'b0, 1'b0, 1'b0, "ones push");
    chk("sd illegal", 64'(out_illegal), 64'd1);
    chk("sd memw", 64'(out_signals.memw), 64'd0);
    chk("sd cond", 64'(out_signals.cond), 64'(Never));
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, "sd pop");
    chk("ones illegal", 64'(out_illegal), 64'd1);
    chk("ones memw", 64'(out_signals.memw), 64'd0);
    chk("ones cond", 64'(out_signals.cond), 64'(Never));
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, "ones pop");

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, rand_insn(), $urandom, $urandom_range(0, 2) != 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0, "random");
    end

    // Reset overrides flush, push and pop.
    step(1'b1, 32'h0010_0113, 32'h600, 1'b0, 1'b0, 1'b0, "pre-reset");
    step(1'b1, 32'h0020_0193, 32'h604, 1'b1, 1'b1, 1'b1, "reset");
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, "post-reset");
    chk("post-reset out_valid", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 Parameter DEPTH, default 2, number of decoded-entry slots (legal range 1..16).
REQ-002 Parameter RESET_PC, default 32'h0, pc value driven in the idle/NOP output bundle.
REQ-003 clk  input  1  clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 flush  input  1  discard all queued entries (branch redirect).
REQ-006 in_valid  input  1  fetch offers an instruction.
REQ-007 in_ready  output  1  queue can accept an instruction this cycle.
REQ-008 in_insn  input  32  raw RV32 instruction word.
REQ-009 in_pc  input  32  address of in_insn.
REQ-010 out_valid  output  1  head entry valid.
REQ-011 out_ready  input  1  execute consumes head entry this cycle.
REQ-012 out_signals  output  Signals  decoded control bundle of head entry.
REQ-013 out_illegal  output  1  head entry decoded as illegal.

Function
REQ-014 Push SHALL occur when in_valid && in_ready && !flush; pop SHALL occur when out_valid && out_ready && !flush.
REQ-015 Decode SHALL happen on push; the queue stores decoded bundles, not raw words.
REQ-016 Latency SHALL be exactly 1 cycle: an entry pushed in cycle N is first visible at the output in cycle N+1 when the queue was empty; no combinational in-to-out path.
REQ-017 in_ready SHALL equal (count < DEPTH), with no combinational dependence on out_ready; at full with a simultaneous pop, the push is refused.
REQ-018 Simultaneous push and pop at 0 < count < DEPTH SHALL leave count unchanged.
REQ-019 Read and write pointers SHALL wrap from DEPTH-1 to 0; DEPTH need not be a power of two.
REQ-020 count width SHALL be $clog2(DEPTH+1); out_valid = (count != 0).
REQ-021 While out_valid=0, out_signals SHALL be the NOP bundle: valid 0, pc RESET_PC, op Add, wreg 0, asel/bsel Register, pcsel 0, cond Never, memr 0, memw 0, memt LoadByte; out_illegal 0.
REQ-022 While out_valid=1, out_signals.valid SHALL be 1.
REQ-023 Flush SHALL take priority: the next cycle has count 0 and both pointers 0; any same-cycle push or pop is dropped.
REQ-024 Decode table: RegReg/RegImm ALU ops by funct3/funct7; Branch op Sub (funct3 0,1,4,5) or USub (6,7), with cond Zero/NotZero/Carry/NotCarry/Carry/NotCarry; Jal/Jalr op Add, asel ProgramCounter, bsel Immediate, cond Always, pcsel = Jalr; Load memr=1 with memt from funct3 0,1,2,4,5; Store memw=1 with funct3 0,1,2; Lui asel Register; Auipc asel ProgramCounter.
REQ-025 Unknown opcode, undefined funct3/funct7 combination, Load funct3 3/6/7, or Store funct3 >2 SHALL set illegal=1 with wreg 0, memr 0, memw 0, cond Never, op Add; the entry still occupies a slot.
REQ-026 Branch and Store entries SHALL have wreg 0.

Reset
REQ-027 rst SHALL clear count and pointers to 0 on the next clock edge, forcing out_valid 0, the NOP bundle, and in_ready 1; it overrides flush, push and pop.
REQ-028 Storage array contents need no reset.

Configuration
REQ-029 Macro DECODE_QUEUE_MEXT_EN: when defined, RegReg with funct7 0x01 SHALL decode funct3 0-7 to Mul, Mulh, Mulhsu, Mulhu, Div, Divu, Rem, Remu, with illegal=0; when undefined, funct7 0x01 SHALL decode as illegal per REQ-025.

Structure
REQ-030 Signals, Op (including the eight M-extension members, unconditionally), Cond, Sel, MemType and Opcode SHALL live in package Common.
REQ-031 Combinational decode SHALL be a sub-module insn_decoder (insn, pc -> Signals, illegal); decode_queue instantiates one and owns the storage, pointers and handshake.

Verification
REQ-032 Reset then push 0x00500093 (addi x1,x0,5) at pc 0x100 -> next cycle out_valid 1, op Add, wreg 1, bsel Immediate, pc 0x100.
REQ-033 DEPTH=2, out_ready 0, push three instructions -> in_ready 0 after the second push, third not accepted; then out_ready 1 -> entries drain in order.
REQ-034 Full queue, in_valid 1 and out_ready 1 held -> one pop per cycle, push accepted in the cycle after in_ready rises, no loss or duplication across 20 instructions, pointer wrap exercised.
REQ-035 Two entries queued, flush with simultaneous push -> next cycle out_valid 0, count 0, pushed instruction absent.
REQ-036 Push 0x02208033 (mul) -> with DECODE_QUEUE_MEXT_EN op Mul, illegal 0; without the macro illegal 1, wreg 0.
REQ-037 Push 0x0000B023 (store funct3 3) and 0xFFFFFFFF -> both out_illegal 1, memw 0, cond Never.
